// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: per-lane RV32I immediate extension registered behind a valid/ready skid buffer
module imm_extend_pipe #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int SKID  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*25-1:0]   in_instr,
  input  logic [LANES*3-1:0]    in_immsrc,
  input  logic [LANES-1:0]      in_lane_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*XLEN-1:0] out_imm,
  output logic [LANES-1:0]      out_lane_en,
  output logic [LANES-1:0]      out_illegal
);
  typedef struct packed {
    logic [LANES*XLEN-1:0] imm;
    logic [LANES-1:0]      en;
    logic [LANES-1:0]      ill;
  } bundle_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  bundle_t new_b, main_q, main_d, skid_q, skid_d;
  state_t state_q, state_d;
  logic rdy_q, acc, dlv;
  // v holds instr[31:7], so instr bit n lives at v[n-7]
  function automatic logic [XLEN-1:0] ext(input logic [24:0] v, input logic [2:0] s);
    logic [XLEN-1:0] r;
    r = {XLEN{v[24]}};
    case (s)
      3'd0: r[11:0] = v[24:13];
      3'd1: r[11:0] = {v[24:18], v[4:0]};
      3'd2: r[11:0] = {v[0], v[23:18], v[4:1], 1'b0};
      3'd3: r[19:0] = {v[12:5], v[13], v[23:14], 1'b0};
      3'd4: r[31:0] = {v[24:5], 12'b0};
      3'd5: r = XLEN'(v[17:13]);
      default: r = '0;
    endcase
    return r;
  endfunction
  always_comb begin
    new_b = '0;
    for (int k = 0; k < LANES; k++) begin
      new_b.en[k] = in_lane_en[k];
      new_b.ill[k] = in_lane_en[k] & in_immsrc[3*k+2] & in_immsrc[3*k+1];
      new_b.imm[k*XLEN +: XLEN] = in_lane_en[k] ? ext(in_instr[25*k +: 25], in_immsrc[3*k +: 3]) : '0;
    end
  end
  assign out_valid = state_q != EMPTY;
  assign in_ready  = ~reset & (SKID != 0 ? rdy_q : (out_ready | ~out_valid));
  assign acc = in_valid & in_ready;
  assign dlv = out_valid & out_ready;
  assign {out_imm, out_lane_en, out_illegal} = main_q;
  // without a skid register, accept in ONE implies deliver, so TWO is unreachable
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        state_d = acc ? ONE : EMPTY;
        main_d  = acc ? new_b : main_q;
      end
      ONE: begin
        state_d = acc ? (dlv ? ONE : TWO) : (dlv ? EMPTY : ONE);
        main_d  = acc & dlv ? new_b : main_q;
        skid_d  = acc & ~dlv ? new_b : skid_q;
      end
      TWO: begin
        state_d = dlv ? ONE : TWO;
        main_d  = dlv ? skid_q : main_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= state_d != TWO;
    end
  end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Multi-lane, pipelined immediate generator for the superscalar decode stage. Per issue lane, it extends the immediate of any RV32I format to XLEN bits. It adds a format-illegal flag and registers results behind a valid/ready skid buffer, so decode back-pressure does not create a combinational ready path. It sits between the instruction-fetch bundle register and the decode/issue pipeline register.

Parameters:
LANES, 2, number of issue lanes processed per transaction (1..4)
XLEN, 32, output immediate width; must be >= 32; all formats sign-extend from instr bit 31 except SHAMT
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register, in_ready = out_ready | ~out_valid

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream bundle valid
in_ready  output  1  block can accept a bundle this cycle
in_instr  input  LANES*25  per lane instr[31:7]; lane k at bits [25k+24:25k]
in_immsrc  input  LANES*3  per lane format select; lane k at [3k+2:3k]
in_lane_en  input  LANES  per lane slot-occupied flag
out_valid  output  1  output bundle valid
out_ready  input  1  downstream accepts the bundle
out_imm  output  LANES*XLEN  per lane extended immediate
out_lane_en  output  LANES  registered copy of in_lane_en
out_illegal  output  LANES  per lane unsupported-format flag

Behaviour:
- ImmSrc encoding, with S = instr[31] replicated to XLEN:
  - 000 I: S, instr[31:20].
  - 001 S: S, instr[31:25], instr[11:7].
  - 010 B: S, instr[7], instr[30:25], instr[11:8], 0.
  - 011 J: S, instr[19:12], instr[20], instr[30:21], 0.
  - 100 U: S above bit 31, instr[31:12], 12'b0.
  - 101 SHAMT: zero-extended instr[24:20].
  - 110/111: imm = 0, out_illegal = 1.
- J and U are distinct encodings; 11 is no longer U.
- Lanes with in_lane_en = 0 produce imm = 0 and illegal = 0, regardless of immsrc.
- Transfer rules:
  - A bundle is accepted on an edge where in_valid & in_ready.
  - A bundle is delivered on an edge where out_valid & out_ready.
  - Latency is 1 cycle: an accepted bundle is visible on out_* at the next edge when the path is empty.
  - out_* hold stable while out_valid & ~out_ready.
- SKID=1 state machine, tracking the main register and the skid register:
  - EMPTY: accept -> ONE.
  - ONE: accept & ~deliver -> TWO (new bundle goes to skid). Deliver & ~accept -> EMPTY. Accept & deliver -> ONE (new bundle goes to main).
  - TWO: in_ready = 0. Deliver -> ONE (skid moves to main the same edge).
  - in_ready = ~skid_valid, driven from a flop.
- SKID=0: one register. in_ready = out_ready | ~out_valid. Simultaneous accept and deliver replaces the contents in the same cycle.
- Ordering: strict FIFO order, with no drop or duplication under any valid/ready pattern.
- Reset:
  - out_valid = 0, out_imm = 0, out_lane_en = 0, out_illegal = 0.
  - Skid buffer is emptied and state = EMPTY.
  - in_ready = 0 while reset is high and 1 in the first cycle after reset.
  - Reset mid-transfer discards all held bundles.
- in_valid asserted during reset is ignored.
- Upstream must hold in_* stable while in_valid & ~in_ready; the block does not check this.

Test Plan:
- LANES=2, XLEN=32; lane0 I instr 0xFFF00093, lane1 S instr 0xFE112C23; both lanes enabled, out_ready=1 -> one cycle later out_valid=1, imm0=0xFFFFFFFF, imm1=0xFFFFFFF8, illegal=00.
- lane0 B 0xFE000EE3 -> 0xFFFFFFFC. lane1 J 0x001000EF -> 0x00000800. Next bundle: lane0 U 0x123450B7 -> 0x12345000; lane1 SHAMT 0x01F0D093 -> 0x0000001F.
- Format checks:
  - lane0 immsrc=110 with enable=1 -> imm0=0, illegal[0]=1.
  - lane1 enable=0 with immsrc=000, instr 0xFFF00093 -> imm1=0, illegal[1]=0, out_lane_en=01.
- SKID=1 back-pressure: out_ready=0, send bundles A, B, C back-to-back. Required: A and B accepted, in_ready=0 from the cycle after B, C held. Raise out_ready -> A, B, C delivered on consecutive cycles, in order, with in_ready returning to 1.
- Streaming: in_valid=1 and out_ready=1 continuously for 8 bundles -> throughput of one bundle per cycle with in_ready constantly 1.
- Random out_ready toggling over 1000 bundles -> scoreboard matches exactly.
- Reset mid-flow: with the state at TWO, assert reset for 1 cycle. Required: out_valid=0 and out_* zero on the next edge, in_ready=1 the cycle after reset deasserts, no stale bundle delivered.
- XLEN=64: I instr 0x80000093 -> imm 0xFFFFFFFFFFFFF800; U instr 0x800000B7 -> 0xFFFFFFFF80000000.
